// File: rtl/jtag_master.sv
// jtag_master: clk-domain JTAG initiator. Runs one command at a time (TAP reset, IR scan or DR
// scan) against a TAP slave, starting and ending every walk in RunTestIdle, and returns the
// captured tdo bits with a one-cycle response strobe.
//
// Ports:
//   clk, hard_rst        system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_type 0=reset 1=IR 2=DR 3=reset
//   cmd_len, cmd_din     scan length (0 -> 1, >DRMAX -> DRMAX) and tdi data, bit 0 first
//   rsp_valid, rsp_dout  one-cycle completion pulse and captured tdo (bits >= len are 0)
//   tck, tms, tdi, tdo   JTAG pins
module jtag_master #(
   parameter int unsigned DIV    = 4,
   parameter int unsigned IRsize = 5,
   parameter int unsigned DRMAX  = 96,
   parameter int unsigned LENW   = 7
) (
   input  logic             clk,
   input  logic             hard_rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_type,
   input  logic [LENW-1:0]  cmd_len,
   input  logic [DRMAX-1:0] cmd_din,
   output logic             rsp_valid,
   output logic [DRMAX-1:0] rsp_dout,
   output logic             tck,
   output logic             tms,
   output logic             tdi,
   input  logic             tdo
);

   if (DIV < 1 || IRsize < 1 || IRsize > DRMAX || LENW < 3 || (1 << LENW) <= DRMAX) begin
      : g_param_check
      $error("jtag_master: illegal parameter set");
   end

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RST_SEQ = 3'd1;
   localparam logic [2:0] ST_HDR     = 3'd2;
   localparam logic [2:0] ST_SHIFT   = 3'd3;
   localparam logic [2:0] ST_TAIL    = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   localparam int unsigned      CNTW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(DIV - 1);
   localparam logic [LENW-1:0]  LEN_MAX  = LENW'(DRMAX);

   logic [2:0]       state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             tck_q, tck_d;
   logic             tms_q, tms_d;
   logic             tdi_q, tdi_d;
   logic [LENW-1:0]  bit_q, bit_d;
   logic             auto_q, auto_d;   // reset walk issued by hard_rst, no response owed
   logic             is_ir_q, is_ir_d;
   logic [LENW-1:0]  len_q, len_d;
   logic [DRMAX-1:0] din_q, din_d;
   logic [DRMAX-1:0] cap_q, cap_d;
   logic [DRMAX-1:0] dout_q, dout_d;

   logic             last_bit;
   logic [LENW-1:0]  len_eff;

   // tms value for bit b of a phase, counted from RunTestIdle.
   function automatic logic tms_of(input logic [2:0] st, input logic [LENW-1:0] b,
                                   input logic ir, input logic [LENW-1:0] l);
      logic t;
      case (st)
         ST_RST_SEQ: t = (b < LENW'(5));
         ST_HDR:     t = ir ? (b < LENW'(2)) : (b == LENW'(0));
         ST_SHIFT:   t = (b == l - LENW'(1));
         ST_TAIL:    t = (b == LENW'(0));
         default:    t = 1'b0;
      endcase
      return t;
   endfunction

   always_comb begin
      len_eff = cmd_len;
      if (cmd_len == '0) begin
         len_eff = LENW'(1);
      end else if (cmd_len > LEN_MAX) begin
         len_eff = LEN_MAX;
      end
   end

   always_comb begin
      last_bit = 1'b0;
      case (state_q)
         ST_RST_SEQ: last_bit = (bit_q == LENW'(5));
         ST_HDR:     last_bit = (bit_q == (is_ir_q ? LENW'(3) : LENW'(2)));
         ST_SHIFT:   last_bit = (bit_q == len_q - LENW'(1));
         ST_TAIL:    last_bit = (bit_q == LENW'(1));
         default:    last_bit = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tck_d   = tck_q;
      bit_d   = bit_q;
      auto_d  = auto_q;
      is_ir_d = is_ir_q;
      len_d   = len_q;
      din_d   = din_q;
      cap_d   = cap_q;
      dout_d  = dout_q;

      if (state_q == ST_IDLE || state_q == ST_DONE) begin
         state_d = ST_IDLE;
         if (cmd_valid) begin
            is_ir_d = (cmd_type == 2'd1);
            len_d   = len_eff;
            din_d   = cmd_din;
            cap_d   = '0;
            auto_d  = 1'b0;
            cnt_d   = '0;
            tck_d   = 1'b0;
            bit_d   = '0;
            state_d = (cmd_type == 2'd1 || cmd_type == 2'd2) ? ST_HDR : ST_RST_SEQ;
         end
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         tck_d = ~tck_q;
         if (!tck_q) begin
            // Edge driving tck high: slave's tdo has been stable since the last fall.
            if (state_q == ST_SHIFT) begin
               cap_d[bit_q] = tdo;
            end
         end else if (!last_bit) begin
            bit_d = bit_q + LENW'(1);
         end else begin
            bit_d = '0;
            case (state_q)
               ST_RST_SEQ: state_d = auto_q ? ST_IDLE : ST_DONE;
               ST_HDR:     state_d = ST_SHIFT;
               ST_SHIFT:   state_d = ST_TAIL;
               default:    state_d = ST_DONE;
            endcase
            if (state_d == ST_DONE) begin
               dout_d = cap_q;
            end
         end
      end else begin
         cnt_d = cnt_q + CNTW'(1);
      end

      // tms/tdi only change when the bit index or phase changes, i.e. on tck fall or accept.
      tms_d = tms_of(state_d, bit_d, is_ir_d, len_d);
      tdi_d = (state_d == ST_SHIFT) ? din_d[bit_d] : 1'b0;
   end

   always_ff @(posedge clk or negedge hard_rst) begin
      if (!hard_rst) begin
         state_q <= ST_RST_SEQ;
         cnt_q   <= '0;
         tck_q   <= 1'b0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
         bit_q   <= '0;
         auto_q  <= 1'b1;
         is_ir_q <= 1'b0;
         len_q   <= '0;
         din_q   <= '0;
         cap_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tck_q   <= tck_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         bit_q   <= bit_d;
         auto_q  <= auto_d;
         is_ir_q <= is_ir_d;
         len_q   <= len_d;
         din_q   <= din_d;
         cap_q   <= cap_d;
         dout_q  <= dout_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign rsp_valid = (state_q == ST_DONE);
   assign rsp_dout  = dout_q;
   assign tck       = tck_q;
   assign tms       = tms_q;
   assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: behavioural TAP slave (IR with reset value 1, 40-bit ID register on
// instruction 0, bypass otherwise), a command table, a response scoreboard and hand-written
// reset-abort and auto-reset sequences.
module tb_jtag_master;
   localparam int unsigned DIV   = 2;
   localparam int unsigned DRMAX = 96;
   localparam int unsigned LENW  = 7;
   localparam logic [39:0] ID     = 40'h12_3456_789A;
   localparam logic [4:0]  IR_RST = 5'h01;

   localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6,
                  EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13,
                  EX2IR = 14, UPIR = 15;

   logic             clk = 1'b0;
   logic             hard_rst = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_type = 2'd0;
   logic [LENW-1:0]  cmd_len = '0;
   logic [DRMAX-1:0] cmd_din = '0;
   logic             rsp_valid;
   logic [DRMAX-1:0] rsp_dout;
   logic             tck, tms, tdi;
   logic             tdo = 1'b0;

   int vec_cnt = 0;
   int miss_cnt = 0;

   typedef struct {
      logic [DRMAX-1:0] dout;
      int               n;
      logic [127:0]     tmsv;
   } exp_t;

   typedef struct {
      logic [1:0]       typ;
      logic [LENW-1:0]  len;
      logic [DRMAX-1:0] din;
      bit               b2b;
      int               bits;   // expected tck bit count
   } vec_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   vec_t       vecs[12];
   logic [4:0] exp_ir = IR_RST;

   // TAP slave model
   int               tap_st = TLR;
   logic [4:0]       s_ir = IR_RST;
   logic [DRMAX-1:0] s_sr = '0;
   int               s_len = 1;
   int               tck_total = 0;
   int               tck_base = 0;
   logic             tms_hist[$];

   always #5 clk = ~clk;

   jtag_master #(
      .DIV(DIV), .IRsize(5), .DRMAX(DRMAX), .LENW(LENW)
   ) dut (
      .clk(clk), .hard_rst(hard_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_din(cmd_din), .rsp_valid(rsp_valid),
      .rsp_dout(rsp_dout), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
   );

   function automatic int tap_next(input int st, input logic m);
      int r;
      case (st)
         TLR:     r = m ? TLR   : RTI;
         RTI:     r = m ? SELDR : RTI;
         SELDR:   r = m ? SELIR : CAPDR;
         CAPDR:   r = m ? EX1DR : SHDR;
         SHDR:    r = m ? EX1DR : SHDR;
         EX1DR:   r = m ? UPDR  : PADR;
         PADR:    r = m ? EX2DR : PADR;
         EX2DR:   r = m ? UPDR  : SHDR;
         UPDR:    r = m ? SELDR : RTI;
         SELIR:   r = m ? TLR   : CAPIR;
         CAPIR:   r = m ? EX1IR : SHIR;
         SHIR:    r = m ? EX1IR : SHIR;
         EX1IR:   r = m ? UPIR  : PAIR;
         PAIR:    r = m ? EX2IR : PAIR;
         EX2IR:   r = m ? UPIR  : SHIR;
         default: r = m ? SELDR : RTI;
      endcase
      return r;
   endfunction

   always @(posedge tck) begin
      tms_hist.push_back(tms);
      tck_total++;
      case (tap_st)
         TLR:   s_ir = IR_RST;
         CAPIR: begin s_sr = '0; s_sr[4:0] = s_ir; s_len = 5; end
         CAPDR: begin
            s_sr = '0;
            if (s_ir == 5'h00) begin s_sr[39:0] = ID; s_len = 40; end
            else s_len = 1;
         end
         SHIR, SHDR: begin s_sr = s_sr >> 1; s_sr[s_len-1] = tdi; end
         UPIR:  s_ir = s_sr[4:0];
         default: ;
      endcase
      tap_st = tap_next(tap_st, tms);
   end

   always @(negedge tck) tdo = (tap_st == SHDR || tap_st == SHIR) ? s_sr[0] : 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      vec_cnt++;
      miss_cnt++;
      $display("FAIL %s: got event/timeout, expected none", name);
   endtask

   function automatic logic [127:0] tms_window(input int base, input int cnt);
      logic [127:0] v;
      v = '0;
      for (int j = 0; j < cnt && j < 128; j++) v[j] = tms_hist[base+j];
      return v;
   endfunction

   // Reference: expected dout and tms stream for one command; updates the tracked IR.
   function automatic void model(input logic [1:0] typ, input logic [LENW-1:0] len,
                                 input logic [DRMAX-1:0] din, inout logic [4:0] ir,
                                 output exp_t e);
      int l;
      int h;
      logic [DRMAX+39:0] s;
      l = (len == 0) ? 1 : ((len > DRMAX) ? DRMAX : int'(len));
      e.dout = '0;
      e.tmsv = '0;
      e.n = 0;
      s = '0;
      if (typ == 2'd1 || typ == 2'd2) begin
         if (typ == 2'd1) begin
            s[4:0] = ir;
            s[DRMAX+4:5] = din;
            h = 4;
            e.tmsv[1:0] = 2'b11;
         end else begin
            if (ir == 5'h00) s = {din, ID};
            else s[DRMAX:1] = din;
            h = 3;
            e.tmsv[0] = 1'b1;
         end
         for (int i = 0; i < l; i++) e.dout[i] = s[i];
         if (typ == 2'd1) ir = s[l +: 5];
         e.tmsv[h+l-1] = 1'b1;
         e.tmsv[h+l] = 1'b1;
      end else begin
         e.tmsv[4:0] = 5'h1F;
         ir = IR_RST;
      end
   endfunction

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (sb_q.size() == 0) begin
            flag("unexpected_rsp_valid");
         end else begin
            mon_e = sb_q.pop_front();
            check("rsp_dout", rsp_dout, mon_e.dout);
            check("tck_bits", tck_total - tck_base, mon_e.n);
            check("tms_seq", tms_window(tck_base, tck_total - tck_base), mon_e.tmsv);
            check("slave_in_rti", tap_st, RTI);
         end
      end
   end

   task automatic send_cmd(input logic [1:0] typ, input logic [LENW-1:0] len,
                           input logic [DRMAX-1:0] din, input bit b2b, input int bits);
      exp_t e;
      int   n;
      n = 0;
      if (!b2b) begin
         while ((sb_q.size() != 0 || !cmd_ready) && n < 5000) begin @(negedge clk); n++; end
      end
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_type = typ;
      cmd_len = len;
      cmd_din = din;
      n = 0;
      while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         flag("accept_timeout");
         cmd_valid = 1'b0;
         return;
      end
      if (b2b) check("b2b_on_rsp_valid", rsp_valid, 1'b1);
      model(typ, len, din, exp_ir, e);
      e.n = bits;
      sb_q.push_back(e);
      @(posedge clk);
      n = 1;
      @(negedge clk);
      cmd_valid = 1'b0;
      tck_base = tck_total;
      while (!tck && n < 100) begin @(posedge clk); n++; @(negedge clk); end
      check("first_rise_latency", n, DIV + 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_tck"}, tck, 1'b0);
      check({tag, "_tms"}, tms, 1'b1);
      check({tag, "_tdi"}, tdi, 1'b0);
      check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
      check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check({tag, "_rsp_dout"}, rsp_dout, '0);
   endtask

   task automatic release_and_check();
      int n;
      @(negedge clk);
      tck_base = tck_total;
      hard_rst = 1'b1;
      n = 0;
      while (!cmd_ready && n < 1000) begin @(posedge clk); n++; @(negedge clk); end
      check("auto_rst_cycles", n, 12 * DIV);
      check("auto_rst_bits", tck_total - tck_base, 6);
      check("auto_rst_tms", tms_window(tck_base, tck_total - tck_base), 128'h1F);
      check("auto_rst_slave_rti", tap_st, RTI);
      exp_ir = IR_RST;
   endtask

   initial begin
      int n;
      vecs[0]  = '{2'd1, 7'd5,   96'h0,                            1'b0, 11};
      vecs[1]  = '{2'd2, 7'd40,  96'h0,                            1'b0, 45};
      vecs[2]  = '{2'd2, 7'd0,   96'h3,                            1'b0, 6};
      vecs[3]  = '{2'd2, 7'd127, 96'hDEAD_BEEF_0123_4567_89AB_CDEF, 1'b1, 101};
      vecs[4]  = '{2'd1, 7'd5,   96'h1F,                           1'b1, 11};
      vecs[5]  = '{2'd2, 7'd8,   96'hA5,                           1'b1, 13};
      vecs[6]  = '{2'd3, 7'd0,   96'h0,                            1'b1, 6};
      vecs[7]  = '{2'd1, 7'd7,   96'h55,                           1'b0, 13};
      vecs[8]  = '{2'd2, 7'd96,  {96{1'b1}},                       1'b1, 101};
      vecs[9]  = '{2'd0, 7'd0,   96'h0,                            1'b0, 6};
      vecs[10] = '{2'd1, 7'd1,   96'h1,                            1'b0, 7};
      vecs[11] = '{2'd2, 7'd2,   96'h3,                            1'b0, 7};

      repeat (3) @(negedge clk);
      check_reset_values("por");
      release_and_check();

      foreach (vecs[i]) send_cmd(vecs[i].typ, vecs[i].len, vecs[i].din, vecs[i].b2b, vecs[i].bits);

      // Abort a DR scan during its 20th shift bit (3 header bits precede it).
      send_cmd(2'd1, 7'd5, 96'h0, 1'b0, 11);
      send_cmd(2'd2, 7'd60, 96'h0F0F_0F0F, 1'b0, 65);
      n = 0;
      while ((tck_total - tck_base) < 23 && n < 2000) begin @(negedge clk); n++; end
      check("abort_point", tck_total - tck_base, 23);
      hard_rst = 1'b0;
      #1;
      check_reset_values("abort");
      sb_q.delete();
      repeat (5) @(negedge clk);
      check_reset_values("abort_hold");
      release_and_check();

      send_cmd(2'd1, 7'd5, 96'h0, 1'b0, 11);
      send_cmd(2'd2, 7'd40, 96'h0, 1'b1, 45);
      n = 0;
      while (sb_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
      if (sb_q.size() != 0) flag("final_rsp_timeout");
      repeat (20) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miss_cnt);
      $fatal(1, "watchdog");
   end

endmodule
